hms_clock_core: RTL
===================

// Module: hms_clock_core
// PURPOSE
//   Single-clock HH:MM:SS timekeeping core with a built-in prescaler, button debounce and a
//   CLOCK/SETUP mode FSM. Counter fields advance on synchronous enables, not derived clocks.
//   Drives binary sec/min/hour to the digit-split, 7-seg decode and scan-display stages.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per 1 s tick (>=2)
//   DB_CYCLES  500_000     consecutive stable cycles before a button level is accepted (>=1)
//   HOUR_MAX   23          last hour value before wrap to 0 (23 = 24 h, 11 = 12 h count)
// PORTS
//   clk         in   1  system clock (50 MHz)
//   rst_n       in   1  reset; asynchronous, active-low
//   i_sw_mode   in   1  raw button, active-low: toggle CLOCK/SETUP
//   i_sw_pos    in   1  raw button, active-low: select field in SETUP
//   i_sw_inc    in   1  raw button, active-low: increment selected field in SETUP
//   o_sec       out  6  seconds 0..59
//   o_min       out  6  minutes 0..59
//   o_hour      out  5  hours 0..HOUR_MAX
//   o_mode      out  1  0 = CLOCK, 1 = SETUP
//   o_position  out  2  0 = SEC, 1 = MIN, 2 = HOUR (3 never produced)
//   o_tick      out  1  one-cycle pulse per 1 s tick
//   o_day_hit   out  1  one-cycle pulse on HOUR_MAX:59:59 -> 00:00:00 wrap
//   o_blank     out  3  per-field blank mask {hour,min,sec} for display blinking
// BEHAVIOUR
//   Reset: all outputs 0; prescaler, debounce counters and synchronisers cleared (sync FFs to 1).
//   Prescaler: counts 0..TICK_DIV-1 in CLOCK; o_tick=1 in the cycle count==TICK_DIV-1, then 0.
//     Held at 0 in SETUP (no o_tick); on return to CLOCK the first tick comes TICK_DIV cycles later.
//   Buttons: 2-FF synchroniser, then per-button stable counter; debounced level updates only after
//     DB_CYCLES equal consecutive samples; press event = debounced 1->0, exactly one cycle.
//     Press latency from raw edge: 2 + DB_CYCLES cycles. Holding a button gives one event only.
//   Mode FSM: CLOCK --mode press--> SETUP (o_position forced to SEC); SETUP --mode press--> CLOCK.
//   Position: SETUP only, pos press cycles SEC->MIN->HOUR->SEC; ignored in CLOCK.
//   Simultaneous events, same cycle: mode press wins; pos/inc presses that cycle are discarded.
//   CLOCK counting, on o_tick: sec+1; sec==59 -> sec=0 and min+1; min==59 (with carry) -> min=0
//     and hour+1; hour==HOUR_MAX (with carry) -> hour=0 and o_day_hit=1. All fields update in
//     the same cycle as o_tick (registered outputs valid the following cycle).
//   SETUP: inc press adds 1 to the selected field only; wraps 59->0 / HOUR_MAX->0, no carry,
//     no o_day_hit. inc ignored in CLOCK.
//   Fields never leave range; an out-of-range value (not reachable) wraps to 0 on next increment.
//   Reset mid-operation: asynchronous clear to reset values regardless of mode or pending press.
// CONFIGURATION
//   HMS_BLINK_EN defined: in SETUP the o_blank bit of the selected field toggles every TICK_DIV/2
//     cycles (own counter); bit starts 0 on entering SETUP, on each pos press and each inc press
//     (value always visible right after an edit). Other bits 0. All bits 0 in CLOCK.
//   HMS_BLINK_EN undefined: o_blank tied to 3'b000; port kept for interface stability.
// TESTING (bench: TICK_DIV=4, DB_CYCLES=3, HOUR_MAX=23)
//   1. Reset, run 240 clk -> 60 o_tick pulses 4 clk apart; o_sec 0..59 then 0, o_min=1.
//   2. Set 23:59:59 via SETUP, return to CLOCK, wait 4 clk -> 00:00:00, o_day_hit high 1 cycle.
//   3. i_sw_inc low 2 clk (bounce) -> no change; low 20 clk -> exactly one increment after 5 clk.
//   4. SETUP, pos=MIN, min=59, hour=5, inc press -> min=0, hour=5, o_sec unchanged, no o_day_hit.
//   5. mode and pos presses same cycle in SETUP -> o_mode=0, o_position unchanged.
//   6. rst_n low mid-SETUP (async, between edges) -> all outputs 0 immediately, o_mode=0.
//   7. HMS_BLINK_EN, SETUP pos=HOUR -> o_blank toggles 3'b000/3'b100 every 2 clk; inc resets to 0.

Source files
------------

// File: rtl/hms_clock_core.sv
// hms_clock_core
//   Single-clock HH:MM:SS timekeeping core. A prescaler produces a one-cycle
//   1 s enable (o_tick); three raw active-low buttons are synchronised and
//   debounced into one-cycle press events that drive a CLOCK/SETUP mode FSM.
//   All counter fields advance on synchronous enables only.
//
//   Optional feature macro: HMS_BLINK_EN
//     defined   : o_blank blinks the selected field while in SETUP
//     undefined : o_blank is tied to 3'b000
//
// Parameters
//   TICK_DIV   clk cycles per 1 s tick (>=2)
//   DB_CYCLES  consecutive stable samples before a button level is accepted (>=1)
//   HOUR_MAX   last hour value before wrap to 0 (23 or 11)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   i_sw_mode   raw button, active-low, toggles CLOCK/SETUP
//   i_sw_pos    raw button, active-low, selects field in SETUP
//   i_sw_inc    raw button, active-low, increments selected field in SETUP
//   o_sec       seconds 0..59
//   o_min       minutes 0..59
//   o_hour      hours 0..HOUR_MAX
//   o_mode      0 = CLOCK, 1 = SETUP
//   o_position  0 = SEC, 1 = MIN, 2 = HOUR
//   o_tick      one-cycle pulse per 1 s tick
//   o_day_hit   one-cycle pulse on the HOUR_MAX:59:59 -> 00:00:00 wrap
//   o_blank     per-field blank mask {hour,min,sec}
module hms_clock_core #(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned DB_CYCLES = 500_000,
   parameter int unsigned HOUR_MAX  = 23
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw_mode,
   input  logic       i_sw_pos,
   input  logic       i_sw_inc,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_mode,
   output logic [1:0] o_position,
   output logic       o_tick,
   output logic       o_day_hit,
   output logic [2:0] o_blank
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
   localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX);

   typedef enum logic {
      ST_CLOCK = 1'b0,
      ST_SETUP = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      POS_SEC  = 2'd0,
      POS_MIN  = 2'd1,
      POS_HOUR = 2'd2
   } pos_t;

   // ---------------------------------------------------------------------
   // Button synchronisers and debouncers; bit 0 = mode, 1 = pos, 2 = inc
   // ---------------------------------------------------------------------
   logic [2:0]         raw_btn;
   logic [2:0]         sync1;
   logic [2:0]         sync2;
   logic [2:0]         db_level;
   logic [2:0][DW-1:0] db_cnt;
   logic [2:0]         press;

   assign raw_btn = {i_sw_inc, i_sw_pos, i_sw_mode};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= raw_btn;
         sync2 <= sync1;
      end
   end

   // The counter tracks how many consecutive samples disagreed with the
   // accepted level; any agreeing sample restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_level <= '1;
         db_cnt   <= '0;
      end else begin
         for (int unsigned b = 0; b < 3; b++) begin
            if (sync2[b] == db_level[b]) begin
               db_cnt[b] <= '0;
            end else if (db_cnt[b] == DB_LAST) begin
               db_level[b] <= sync2[b];
               db_cnt[b]   <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + DW'(1);
            end
         end
      end
   end

   // Press event is asserted in the cycle the debounced level falls.
   always_comb begin
      press = '0;
      for (int unsigned b = 0; b < 3; b++) begin
         press[b] = (sync2[b] != db_level[b]) && (db_cnt[b] == DB_LAST) && !sync2[b];
      end
   end

   logic mode_evt;
   logic pos_evt;
   logic inc_evt;

   // A mode press in the same cycle discards pos/inc presses.
   assign mode_evt = press[0];
   assign pos_evt  = press[1] & ~press[0];
   assign inc_evt  = press[2] & ~press[0];

   // ---------------------------------------------------------------------
   // Mode / position FSM
   // ---------------------------------------------------------------------
   mode_t state;
   mode_t state_nxt;
   pos_t  pos;
   pos_t  pos_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CLOCK;
         pos   <= POS_SEC;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      case (state)
         ST_CLOCK: begin
            if (mode_evt) begin
               state_nxt = ST_SETUP;
               pos_nxt   = POS_SEC;
            end
         end
         ST_SETUP: begin
            if (mode_evt) begin
               state_nxt = ST_CLOCK;
            end else if (pos_evt) begin
               case (pos)
                  POS_SEC: pos_nxt = POS_MIN;
                  POS_MIN: pos_nxt = POS_HOUR;
                  default: pos_nxt = POS_SEC;
               endcase
            end
         end
         default: state_nxt = ST_CLOCK;
      endcase
   end

   // ---------------------------------------------------------------------
   // Prescaler: held at 0 outside CLOCK and restarted on any mode change,
   // so the first tick after returning to CLOCK is a full period away.
   // ---------------------------------------------------------------------
   logic [PW-1:0] presc;
   logic          tick;

   assign tick = (state == ST_CLOCK) && (presc == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if ((state != ST_CLOCK) || mode_evt || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Time fields
   // ---------------------------------------------------------------------
   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [4:0] inc_hour(input logic [4:0] v);
      return (v >= HOUR_LAST) ? 5'd0 : v + 5'd1;
   endfunction

   logic [5:0] sec_q,  sec_nxt;
   logic [5:0] min_q,  min_nxt;
   logic [4:0] hour_q, hour_nxt;
   logic       day_q,  day_nxt;

   always_comb begin
      sec_nxt  = sec_q;
      min_nxt  = min_q;
      hour_nxt = hour_q;
      day_nxt  = 1'b0;
      if (tick) begin
         sec_nxt = inc60(sec_q);
         if (sec_q >= 6'd59) begin
            min_nxt = inc60(min_q);
            if (min_q >= 6'd59) begin
               hour_nxt = inc_hour(hour_q);
               if (hour_q >= HOUR_LAST) begin
                  day_nxt = 1'b1;
               end
            end
         end
      end else if ((state == ST_SETUP) && inc_evt) begin
         case (pos)
            POS_SEC:  sec_nxt  = inc60(sec_q);
            POS_MIN:  min_nxt  = inc60(min_q);
            POS_HOUR: hour_nxt = inc_hour(hour_q);
            default:  sec_nxt  = sec_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
         day_q  <= 1'b0;
      end else begin
         sec_q  <= sec_nxt;
         min_q  <= min_nxt;
         hour_q <= hour_nxt;
         day_q  <= day_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Field blink mask
   // ---------------------------------------------------------------------
`ifdef HMS_BLINK_EN
   localparam int unsigned HALF = ((TICK_DIV / 2) > 0) ? (TICK_DIV / 2) : 1;
   localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic          blink_clr;

   // Restart with the field visible whenever it was just selected or edited.
   assign blink_clr = (state != ST_SETUP) || mode_evt || pos_evt || inc_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (blink_clr) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         blink_ph  <= ~blink_ph;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   always_comb begin
      o_blank = 3'b000;
      if ((state == ST_SETUP) && blink_ph) begin
         case (pos)
            POS_SEC:  o_blank = 3'b001;
            POS_MIN:  o_blank = 3'b010;
            POS_HOUR: o_blank = 3'b100;
            default:  o_blank = 3'b000;
         endcase
      end
   end
`else
   assign o_blank = 3'b000;
`endif

   assign o_sec      = sec_q;
   assign o_min      = min_q;
   assign o_hour     = hour_q;
   assign o_mode     = (state == ST_SETUP);
   assign o_position = pos;
   assign o_tick     = tick;
   assign o_day_hit  = day_q;

endmodule
